// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types for the JK bank arbiter: command encoding, lock FSM states and
// the per-bit JK next-state helper.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_e;

  typedef enum logic {
    ARB_S    = 1'b0,
    LOCKED_S = 1'b1
  } arb_state_e;

  function automatic logic jk_next(input jk_cmd_e c, input logic cur);
    case (c)
      JK_CLR:  return 1'b0;
      JK_SET:  return 1'b1;
      JK_TOG:  return ~cur;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bus of the JK bank arbiter. The lock vector only exists when
// JK_ARB_LOCK_EN is defined.
interface jk_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = $clog2(WIDTH)
);
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     cmd;
  logic [NUM_REQ*IDX_W-1:0] idx;
  logic [NUM_REQ-1:0]       gnt;
`ifdef JK_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       lock;

  modport master (output req, cmd, idx, lock, input gnt);
  modport slave  (input req, cmd, idx, lock, output gnt);
`else
  modport master (output req, cmd, idx, input gnt);
  modport slave  (input req, cmd, idx, output gnt);
`endif
endinterface

// File: rtl/jk_bank_arbiter_rr.sv
// Round-robin priority search: the first set req at or after ptr (wrapping)
// wins; returns the one-hot grant and the binary winner index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    win,
  output logic               any
);
  always_comb begin
    int r;
    r   = 0;
    gnt = '0;
    win = '0;
    any = 1'b0;
    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      r = (int'(ptr) + k) % NUM_REQ;
      if (req[r]) begin
        gnt    = '0;
        gnt[r] = 1'b1;
        win    = ID_W'(r);
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter applying one JK command per cycle to a shared bit bank.
// Define JK_ARB_LOCK_EN to add per-requester grant locking (ARB/LOCKED FSM).
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = $clog2(WIDTH),
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  jk_bank_arbiter_if.slave  bus,
  output logic [WIDTH-1:0]  q,
  output logic [ID_W-1:0]   gnt_id,
  output logic              idx_err
);
  logic [WIDTH-1:0]   q_q, q_d;
  logic [ID_W-1:0]    ptr_q, ptr_d, gnt_id_q, gnt_id_d;
  logic               idx_err_q, idx_err_d;
  logic [NUM_REQ-1:0] req_elig, arb_gnt;
  logic [ID_W-1:0]    win;
  logic               any, take, idx_ok;
  jk_cmd_e            cmd_w;
  logic [IDX_W-1:0]   idx_w;

  function automatic logic [ID_W-1:0] inc_ptr(input logic [ID_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

`ifdef JK_ARB_LOCK_EN
  arb_state_e      state_q;
  logic [ID_W-1:0] owner_q;
  logic            own_lock;

  assign own_lock = bus.lock[owner_q];
  // While locked only the owner is eligible; everyone else stalls.
  assign req_elig = (state_q == LOCKED_S) ? (bus.req & (NUM_REQ'(1) << owner_q)) : bus.req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_S;
      owner_q <= '0;
    end else begin
      case (state_q)
        ARB_S:
          if (take && bus.lock[win]) begin
            state_q <= LOCKED_S;
            owner_q <= win;
          end
        LOCKED_S:
          if (!own_lock) state_q <= ARB_S;
        default: state_q <= ARB_S;
      endcase
    end
  end
`else
  assign req_elig = bus.req;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req (req_elig),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .win (win),
    .any (any)
  );

  assign take    = any & ~rst;
  assign bus.gnt = take ? arb_gnt : '0;
  assign cmd_w   = jk_cmd_e'(bus.cmd[2*win +: 2]);
  assign idx_w   = bus.idx[win*IDX_W +: IDX_W];
  assign idx_ok  = int'(idx_w) < WIDTH;

  always_comb begin
    ptr_d = ptr_q;
`ifdef JK_ARB_LOCK_EN
    // A locked sequence keeps ptr frozen until the owner releases.
    if (state_q == ARB_S) begin
      if (take && !bus.lock[win]) ptr_d = inc_ptr(win);
    end else if (!own_lock) begin
      ptr_d = inc_ptr(owner_q);
    end
`else
    if (take) ptr_d = inc_ptr(win);
`endif
  end

  always_comb begin
    q_d = q_q;
    for (int b = 0; b < WIDTH; b++)
      if (take && idx_ok && int'(idx_w) == b) q_d[b] = jk_next(cmd_w, q_q[b]);
    gnt_id_d  = take ? win : gnt_id_q;
    idx_err_d = take & ~idx_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      ptr_q     <= '0;
      gnt_id_q  <= '0;
      idx_err_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign q       = q_q;
  assign gnt_id  = gnt_id_q;
  assign idx_err = idx_err_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with a per-cycle round-robin/JK model
// and literal expectations from the test plan.
module tb_jk_bank_arbiter;
  import jk_pkg::*;

  localparam int N  = 4;
  localparam int W  = 6;
  localparam int IW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] q;
  logic [1:0]   gnt_id;
  logic         idx_err;

  jk_bank_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  jk_bank_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .q       (q),
    .gnt_id  (gnt_id),
    .idx_err (idx_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int           m_ptr    = 0;
  int           m_gid    = 0;
  int           m_owner  = 0;
  bit           m_locked = 1'b0;
  logic         m_ierr   = 1'b0;
  logic [W-1:0] m_q      = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: compare this cycle's outputs, then advance by what the coming edge does.
  task automatic model_cycle();
    logic [N-1:0] eg;
    logic [1:0]   c;
    int           w, r, ix;
    eg = '0;
    w  = -1;
    if (!rst)
      for (int k = 0; k < N; k++) begin
        r = (m_ptr + k) % N;
        if (w < 0 && bus.req[r] && (!m_locked || r == m_owner)) w = r;
      end
    if (w >= 0) eg[w] = 1'b1;
    chk("model_gnt", 32'(bus.gnt), 32'(eg));
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_gnt_id", 32'(gnt_id), m_gid);
    chk("model_idx_err", 32'(idx_err), 32'(m_ierr));
    if (rst) begin
      m_q = '0; m_ptr = 0; m_gid = 0; m_ierr = 1'b0; m_locked = 1'b0; m_owner = 0;
      return;
    end
    m_ierr = 1'b0;
    if (w >= 0) begin
      c     = bus.cmd[2*w +: 2];
      ix    = int'(bus.idx[w*IW +: IW]);
      m_gid = w;
      if (ix >= W) m_ierr = 1'b1;
      else
        case (c)
          2'd1: m_q[ix] = 1'b0;
          2'd2: m_q[ix] = 1'b1;
          2'd3: m_q[ix] = ~m_q[ix];
          default: ;
        endcase
    end
`ifdef JK_ARB_LOCK_EN
    if (m_locked) begin
      if (!bus.lock[m_owner]) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % N;
      end
    end else if (w >= 0) begin
      if (bus.lock[w]) begin
        m_locked = 1'b1;
        m_owner  = w;
      end else m_ptr = (w + 1) % N;
    end
`else
    if (w >= 0) m_ptr = (w + 1) % N;
`endif
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int r, input logic [1:0] c, input int i);
    logic [31:0] iv;
    iv = i;
    bus.req[r]           = 1'b1;
    bus.cmd[2*r +: 2]    = c;
    bus.idx[r*IW +: IW]  = iv[IW-1:0];
  endtask

  task automatic clr_all();
    bus.req = '0;
    bus.cmd = '0;
    bus.idx = '0;
`ifdef JK_ARB_LOCK_EN
    bus.lock = '0;
`endif
  endtask

  task automatic do_reset();
    clr_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    clr_all();
    rst     = 1'b1;
    bus.req = '1;
    #1 chk("rst_gnt_a", 32'(bus.gnt), 0);
    step();
    chk("rst_gnt_b", 32'(bus.gnt), 0);
    step();
    rst     = 1'b0;
    bus.req = '0;
    #1;
    chk("rst_q", 32'(q), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_idx_err", 32'(idx_err), 0);

    // single requester, per-bit commands
    put(1, JK_SET, 3); #1 chk("bit_gnt1", 32'(bus.gnt), 'h2); step(); chk("bit_q1", 32'(q), 'h08);
    put(1, JK_TOG, 3); #1 chk("bit_gnt2", 32'(bus.gnt), 'h2); step(); chk("bit_q2", 32'(q), 'h00);
    put(1, JK_TOG, 3); #1 chk("bit_gnt3", 32'(bus.gnt), 'h2); step(); chk("bit_q3", 32'(q), 'h08);
    put(1, JK_CLR, 3); #1 chk("bit_gnt4", 32'(bus.gnt), 'h2); step(); chk("bit_q4", 32'(q), 'h00);
    chk("bit_gnt_id", 32'(gnt_id), 1);
    bus.req = '0;
    step();

    // fairness, each requester drops after its grant
    do_reset();
    for (int k = 0; k < N; k++) put(k, JK_SET, k);
    for (int k = 0; k < N; k++) begin
      #1 chk("fair_gnt", 32'(bus.gnt), 32'(1) << k);
      step();
      bus.req[k] = 1'b0;
    end
    chk("fair_q", 32'(q), 'h0F);
    chk("fair_gnt_id", 32'(gnt_id), 3);

    // out-of-range index
    do_reset();
    put(2, JK_SET, 7);
    #1 chk("oor_gnt", 32'(bus.gnt), 'h4);
    step();
    bus.req = '0;
    chk("oor_q", 32'(q), 0);
    chk("oor_err_hi", 32'(idx_err), 1);
    chk("oor_gnt_id", 32'(gnt_id), 2);
    step();
    chk("oor_err_lo", 32'(idx_err), 0);

    // same-bit collision; ptr sits at 3 after the out-of-range grant
    put(0, JK_TOG, 5);
    put(3, JK_TOG, 5);
    #1 chk("col_gnt1", 32'(bus.gnt), 'h8);
    step();
    chk("col_q1", 32'(q), 'h20);
    bus.req[3] = 1'b0;
    #1 chk("col_gnt2", 32'(bus.gnt), 'h1);
    step();
    chk("col_q2", 32'(q), 'h00);
    bus.req = '0;
    #1 chk("idle_gnt", 32'(bus.gnt), 0);
    step();

`ifdef JK_ARB_LOCK_EN
    do_reset();
    put(2, JK_SET, 0);
    bus.lock[2] = 1'b1;
    #1 chk("lock_gnt1", 32'(bus.gnt), 'h4);
    step();
    put(0, JK_SET, 1);
    put(1, JK_SET, 2);
    #1 chk("lock_gnt2", 32'(bus.gnt), 'h4);
    step();
    bus.lock[2] = 1'b0;
    #1 chk("lock_gnt3", 32'(bus.gnt), 'h4);
    step();
    bus.req[2] = 1'b0;
    #1 chk("lock_after", 32'(bus.gnt), 'h1);
    step();
    bus.req[0] = 1'b0;
    #1 chk("lock_next", 32'(bus.gnt), 'h2);
    step();
    bus.req = '0;
    step();
    chk("lock_q", 32'(q), 'h07);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
